// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags and sticky misuse flags.
// Latency: a write is readable from the next edge on; read data is registered and rvalid pulses on the edge after acceptance.
// Backpressure: writes are dropped while wfull and reads while rempty; each drop sets overflow or underflow until clr_err.
//
// Ports:
//   clk, rst_n             single clock, asynchronous active-low reset
//   winc, wdata            write request and data; wfull, walmost_full report fill level
//   rinc                   read request; rdata/rvalid carry the registered result; rempty, ralmost_empty report drain level
//   count                  occupancy 0..DEPTH
//   overflow, underflow    sticky error flags; clr_err clears them synchronously
module sync_fifo #(
    parameter int DSIZE      = 8,
    parameter int ASIZE      = 4,
    parameter int AFULL_LVL  = 14,
    parameter int AEMPTY_LVL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int             DEPTH    = 1 << ASIZE;
    localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_LVL);
    localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_LVL);
    localparam logic [ASIZE:0] ONE_C    = {{ASIZE{1'b0}}, 1'b1};

    // Storage is deliberately not reset; pointers define which entries are live.
    logic [DSIZE-1:0] mem_q [DEPTH];

    logic [ASIZE:0]   wptr_q, wptr_d;
    logic [ASIZE:0]   rptr_q, rptr_d;
    logic [ASIZE:0]   cnt_q, cnt_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             full, empty;
    logic             wr_acc, rd_acc;

    // Pointers carry an extra wrap bit so equal low bits distinguish empty (same lap) from full (one lap apart).
    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]) && (wptr_q[ASIZE] != rptr_q[ASIZE]);

    assign wr_acc = winc && !full;
    assign rd_acc = rinc && !empty;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = rd_acc;

        if (wr_acc) begin
            wptr_d = wptr_q + ONE_C;
        end
        if (rd_acc) begin
            rptr_d  = rptr_q + ONE_C;
            rdata_d = mem_q[rptr_q[ASIZE-1:0]];
        end

        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + ONE_C;
            2'b01:   cnt_d = cnt_q - ONE_C;
            default: cnt_d = cnt_q;
        endcase

        // A new error in the same cycle as clr_err must survive the clear.
        ovf_d = (ovf_q && !clr_err) || (winc && full);
        udf_d = (udf_q && !clr_err) || (rinc && empty);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q[ASIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Every output is decoded from registered state only.
    assign wfull         = full;
    assign rempty        = empty;
    assign walmost_full  = (cnt_q >= AFULL_C);
    assign ralmost_empty = (cnt_q <= AEMPTY_C);
    assign count         = cnt_q;
    assign rdata         = rdata_q;
    assign rvalid        = rvalid_q;
    assign overflow      = ovf_q;
    assign underflow     = udf_q;

endmodule
